// File: rtl/dot4_pkg.sv
// Shared definitions for the 4-term single-precision dot-product sequencer.
//   state_e  : sequencer state encoding
//   N_TERMS  : number of product terms
//   FP_ZERO / FP_ONE : handy IEEE-754 single-precision constants
package dot4_pkg;

  localparam int N_TERMS = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD0 = 3'd2,
    S_ADD1 = 3'd3,
    S_ADD2 = 3'd4
  } state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/dot4_sequencer.sv
// dot4_sequencer: time-multiplexes one external combinational fp_mult and one
// external combinational fp_add to compute (a0*b0 + a1*b1) + (a2*b2 + a3*b3).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request, only looked at while idle
//   a0..a3, b0..b3    operands, captured on the accepting edge
//   busy              high while a dot product is in flight
//   done, result      one-cycle completion pulse; result held until next done
//   mul_a/mul_b/mul_y operand/result bus of the shared multiplier
//   add_a/add_b/add_y operand/result bus of the shared adder
module dot4_sequencer #(
  parameter int DATA_W    = 32,
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] b3,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_y,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_y
);
  import dot4_pkg::*;

  state_e                           state_q, state_d;
  logic [1:0]                       idx_q, idx_d;
  logic [N_TERMS-1:0][DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, p_q, p_d;
  logic [DATA_W-1:0]                s0_q, s0_d, s1_q, s1_d, res_q, res_d;
  logic                             done_q, done_d;

  // Last value driven on each operand bus, replayed when IDLE_ZERO=0.
  logic [DATA_W-1:0] mul_a_hq, mul_b_hq, add_a_hq, add_b_hq;

  logic              mul_use, add_use;
  logic [DATA_W-1:0] mul_a_sel, mul_b_sel, add_a_sel, add_b_sel;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    p_d       = p_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    res_d     = res_q;
    done_d    = 1'b0;
    mul_use   = 1'b0;
    add_use   = 1'b0;
    mul_a_sel = '0;
    mul_b_sel = '0;
    add_a_sel = '0;
    add_b_sel = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = {a3, a2, a1, a0};
          opb_d   = {b3, b2, b1, b0};
          idx_d   = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        mul_use       = 1'b1;
        mul_a_sel     = opa_q[idx_q];
        mul_b_sel     = opb_q[idx_q];
        p_d[idx_q]    = mul_y;
        if (idx_q == 2'd3) state_d = S_ADD0;
        else               idx_d   = idx_q + 2'd1;
      end
      S_ADD0: begin
        add_use   = 1'b1;
        add_a_sel = p_q[0];
        add_b_sel = p_q[1];
        s0_d      = add_y;
        state_d   = S_ADD1;
      end
      S_ADD1: begin
        add_use   = 1'b1;
        add_a_sel = p_q[2];
        add_b_sel = p_q[3];
        s1_d      = add_y;
        state_d   = S_ADD2;
      end
      S_ADD2: begin
        add_use   = 1'b1;
        add_a_sel = s0_q;
        add_b_sel = s1_q;
        res_d     = add_y;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mul_a = mul_use ? mul_a_sel : (IDLE_ZERO ? '0 : mul_a_hq);
    mul_b = mul_use ? mul_b_sel : (IDLE_ZERO ? '0 : mul_b_hq);
    add_a = add_use ? add_a_sel : (IDLE_ZERO ? '0 : add_a_hq);
    add_b = add_use ? add_b_sel : (IDLE_ZERO ? '0 : add_b_hq);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      p_q      <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      mul_a_hq <= '0;
      mul_b_hq <= '0;
      add_a_hq <= '0;
      add_b_hq <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      p_q      <= p_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      res_q    <= res_d;
      done_q   <= done_d;
      mul_a_hq <= mul_a;
      mul_b_hq <= mul_b;
      add_a_hq <= add_a;
      add_b_hq <= add_b;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_dot4_sequencer.sv
module tb_dot4_sequencer;
  import dot4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic        busy, done;
  logic [31:0] result, mul_a, mul_b, mul_y, add_a, add_b, add_y;

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [31:0] F1 = 32'h3F80_0000, F2 = 32'h4000_0000,
                          F3 = 32'h4040_0000, F4 = 32'h4080_0000;

  dot4_sequencer #(.DATA_W(32), .IDLE_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .busy(busy), .done(done), .result(result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .add_a(add_a), .add_b(add_b), .add_y(add_y)
  );

  always #5 clk = ~clk;

  // Stand-in FP units: exact for normal numbers and zero, which is all the
  // directed vectors use.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign mul_y = r2f(f2r(mul_a) * f2r(mul_b));
  assign add_y = r2f(f2r(add_a) + f2r(add_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3);
    a0 = x0; a1 = x1; a2 = x2; a3 = x3;
    b0 = y0; b1 = y1; b2 = y2; b3 = y3;
  endtask

  // Bounded wait for done; cyc = ticks taken (max means it never came).
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    set_ops(F1, F2, F3, F4, F1, F1, F1, F1);
    rst_n = 1'b0;
    tick; tick;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_chk++; if (result !== 32'h0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
    n_chk++; if ({mul_a, mul_b, add_a, add_b} !== 128'h0)
      $display("FAIL reset_fpbus got=%h %h %h %h exp=0", mul_a, mul_b, add_a, add_b); else n_pass++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    set_ops(F1, F2, F3, F4, F1, F1, F1, F1);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL basic_busy cyc=%0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
      else n_pass++;
      tick;
    end
    n_chk++; if (busy !== 1'b0 || done !== 1'b1)
      $display("FAIL basic_done got busy=%b done=%b exp busy=0 done=1", busy, done); else n_pass++;
    n_chk++; if (result !== 32'h4120_0000) $display("FAIL basic_result got=%h exp=41200000", result); else n_pass++;
    tick;
    n_chk++; if (done !== 1'b0) $display("FAIL basic_pulse got=%b exp=0", done); else n_pass++;
    n_chk++; if (result !== 32'h4120_0000) $display("FAIL basic_hold got=%h exp=41200000", result); else n_pass++;
  endtask

  task automatic test_garbage;
    int cyc;
    set_ops(F1, F2, F3, F4, F2, F2, F2, F2);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    wait_done(20, cyc);
    n_chk++; if (cyc !== 6) $display("FAIL garbage_latency got=%0d exp=6", cyc); else n_pass++;
    n_chk++; if (result !== 32'h41A0_0000) $display("FAIL garbage_result got=%h exp=41a00000", result); else n_pass++;
    tick;
  endtask

  task automatic test_ignore_start;
    int dones, done_at, cyc;
    dones = 0; done_at = -1;
    set_ops(F1, F2, F3, F4, F1, F1, F1, F1);
    start = 1'b1;
    tick;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        set_ops(F4, F4, F4, F4, F2, F2, F2, F2);
        start = 1'b1;
      end else start = 1'b0;
      tick;
      if (done) begin dones++; done_at = i; end
    end
    n_chk++; if (dones !== 1) $display("FAIL ignore_count got=%0d exp=1", dones); else n_pass++;
    n_chk++; if (done_at !== 7) $display("FAIL ignore_when got=%0d exp=7", done_at); else n_pass++;
    n_chk++; if (result !== 32'h4120_0000) $display("FAIL ignore_result got=%h exp=41200000", result); else n_pass++;

    // start held through the done cycle -> second op accepted right away
    set_ops(F1, F2, F3, F4, F1, F1, F1, F1);
    start = 1'b1;
    tick;
    set_ops(F1, F2, F3, F4, F2, F2, F2, F2);
    wait_done(20, cyc);
    n_chk++; if (cyc !== 7) $display("FAIL b2b_first_lat got=%0d exp=7", cyc); else n_pass++;
    n_chk++; if (result !== 32'h4120_0000) $display("FAIL b2b_first_res got=%h exp=41200000", result); else n_pass++;
    tick;
    start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b exp=1", busy); else n_pass++;
    wait_done(20, cyc);
    n_chk++; if (cyc !== 7) $display("FAIL b2b_second_lat got=%0d exp=7", cyc); else n_pass++;
    n_chk++; if (result !== 32'h41A0_0000) $display("FAIL b2b_second_res got=%h exp=41a00000", result); else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid;
    int dones, cyc;
    dones = 0;
    set_ops(F1, F2, F3, F4, F1, F1, F1, F1);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    // ADD1: adder sees p2, p3
    n_chk++; if (add_a !== F3 || add_b !== F4)
      $display("FAIL mid_add1 got=%h %h exp=%h %h", add_a, add_b, F3, F4); else n_pass++;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_state got busy=%b done=%b exp 0 0", busy, done); else n_pass++;
    n_chk++; if (result !== 32'h0) $display("FAIL mid_result got=%h exp=0", result); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (done) dones++;
    end
    n_chk++; if (dones !== 0) $display("FAIL mid_nodone got=%0d exp=0", dones); else n_pass++;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(20, cyc);
    n_chk++; if (cyc !== 7) $display("FAIL mid_after_lat got=%0d exp=7", cyc); else n_pass++;
    n_chk++; if (result !== 32'h4120_0000) $display("FAIL mid_after_res got=%h exp=41200000", result); else n_pass++;
    tick;
  endtask

  task automatic test_zero_sum;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h3F80_0000; exp_a[1] = 32'hBF80_0000;
    exp_a[2] = 32'h4000_0000; exp_a[3] = 32'hC000_0000;
    set_ops(exp_a[0], exp_a[1], exp_a[2], exp_a[3], F1, F1, F1, F1);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (mul_a !== exp_a[i] || mul_b !== F1)
        $display("FAIL zs_mul%0d got=%h %h exp=%h %h", i, mul_a, mul_b, exp_a[i], F1); else n_pass++;
      n_chk++; if (add_a !== 32'h0 || add_b !== 32'h0)
        $display("FAIL zs_addidle%0d got=%h %h exp=0 0", i, add_a, add_b); else n_pass++;
      tick;
    end
    n_chk++; if (add_a !== exp_a[0] || add_b !== exp_a[1] || mul_a !== 32'h0)
      $display("FAIL zs_add0 got=%h %h mul=%h exp=%h %h 0", add_a, add_b, mul_a, exp_a[0], exp_a[1]); else n_pass++;
    tick;
    n_chk++; if (add_a !== exp_a[2] || add_b !== exp_a[3])
      $display("FAIL zs_add1 got=%h %h exp=%h %h", add_a, add_b, exp_a[2], exp_a[3]); else n_pass++;
    tick;
    n_chk++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL zs_add2 got busy=%b done=%b exp 1 0", busy, done); else n_pass++;
    tick;
    n_chk++; if (done !== 1'b1 || result !== FP_ZERO)
      $display("FAIL zs_result got done=%b res=%h exp done=1 res=0", done, result); else n_pass++;
    tick;
  endtask

  initial begin
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset;
    test_basic;
    test_garbage;
    test_ignore_start;
    test_reset_mid;
    test_zero_sum;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
